// File: rtl/lc3_fetch_prefetch.sv
// LC3 fetch stage: owns the PC, issues imem reads and buffers {instr, npc} in a
// DEPTH-entry circular prefetch queue. LC3_FETCH_PERF_CNT_EN adds fetch/flush counters.

module lc3_fetch_prefetch_entry (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [15:0] wr_instr,
  input  logic [15:0] wr_npc,
  output logic [15:0] instr,
  output logic [15:0] npc
);
  logic [15:0] instr_d, instr_q;
  logic [15:0] npc_d, npc_q;

  always_comb begin
    instr_d = instr_q;
    npc_d   = npc_q;
    if (we) begin
      instr_d = wr_instr;
      npc_d   = wr_npc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q <= '0;
      npc_q   <= '0;
    end else begin
      instr_q <= instr_d;
      npc_q   <= npc_d;
    end
  end

  assign instr = instr_q;
  assign npc   = npc_q;
endmodule

module lc3_fetch_prefetch #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_updatePC,
  input  logic        br_taken,
  input  logic [15:0] taddr,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_dout,
  output logic        dec_valid,
  output logic [15:0] dec_instr,
  output logic [15:0] dec_npc,
  input  logic        dec_ready
`ifdef LC3_FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] flush_count
`endif
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = PW + 1;
  localparam int CW = OW + 1;

  logic [15:0]   pc_d, pc_q;
  logic [PW-1:0] head_d, head_q, tail_d, tail_q;
  logic [OW-1:0] occ_d, occ_q;
  logic          inflight_d, inflight_q;
  logic [15:0]   inflight_addr_d, inflight_addr_q;

  logic          push, pop, issue;
  logic [CW-1:0] used, limit;

  logic [DEPTH-1:0]       ent_we;
  logic [DEPTH-1:0][15:0] ent_instr;
  logic [DEPTH-1:0][15:0] ent_npc;

  assign dec_valid = (occ_q != '0);
  assign dec_instr = ent_instr[head_q];
  assign dec_npc   = ent_npc[head_q];
  assign imem_addr = pc_q;
  assign imem_rd   = issue;

  always_comb begin
    pop   = dec_valid & dec_ready;
    // Credit: queued + in-flight entries, less this cycle's pop, must leave room.
    used  = CW'(occ_q) + CW'(inflight_q);
    limit = CW'(DEPTH) + CW'(pop);
    issue = ~reset & enable_updatePC & ~br_taken & (used < limit);
    // A response arriving during a redirect belongs to the old stream.
    push  = ~reset & inflight_q & ~br_taken;

    pc_d            = pc_q;
    inflight_d      = issue;
    inflight_addr_d = inflight_addr_q;
    head_d          = head_q;
    tail_d          = tail_q;
    occ_d           = occ_q;

    if (br_taken) pc_d = taddr;
    else if (issue) pc_d = pc_q + 16'd1;

    if (issue) inflight_addr_d = pc_q;

    if (br_taken) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      occ_d = occ_q + OW'(push) - OW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q            <= RESET_PC;
      head_q          <= '0;
      tail_q          <= '0;
      occ_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      pc_q            <= pc_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      occ_q           <= occ_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign ent_we[g] = push & (tail_q == PW'(g));
    lc3_fetch_prefetch_entry u_ent (
      .clock    (clock),
      .reset    (reset),
      .we       (ent_we[g]),
      .wr_instr (imem_dout),
      .wr_npc   (inflight_addr_q + 16'd1),
      .instr    (ent_instr[g]),
      .npc      (ent_npc[g])
    );
  end

`ifdef LC3_FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_d, fetch_cnt_q;
  logic [15:0] flush_cnt_d, flush_cnt_q;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {15'd0, pop};
    flush_cnt_d = flush_cnt_q + {15'd0, br_taken};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;
`endif
endmodule

// File: tb/tb_lc3_fetch_prefetch.sv
// Bench for lc3_fetch_prefetch: per-cycle vector table plus an in-order scoreboard
// fed by observed imem reads (memory returns addr ^ 16'hA5A5).

module tb_lc3_fetch_prefetch;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_updatePC = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] taddr = 16'h0000;
  logic [15:0] imem_dout = 16'h0000;
  logic        dec_ready = 1'b0;
  logic [15:0] imem_addr, dec_instr, dec_npc;
  logic        imem_rd, dec_valid;
`ifdef LC3_FETCH_PERF_CNT_EN
  logic [15:0] fetch_count, flush_count;
`endif

  lc3_fetch_prefetch dut (
    .clock           (clock),
    .reset           (reset),
    .enable_updatePC (enable_updatePC),
    .br_taken        (br_taken),
    .taddr           (taddr),
    .imem_addr       (imem_addr),
    .imem_rd         (imem_rd),
    .imem_dout       (imem_dout),
    .dec_valid       (dec_valid),
    .dec_instr       (dec_instr),
    .dec_npc         (dec_npc),
    .dec_ready       (dec_ready)
`ifdef LC3_FETCH_PERF_CNT_EN
    ,
    .fetch_count     (fetch_count),
    .flush_count     (flush_count)
`endif
  );

  always #5 clock = ~clock;

  // Instruction memory: one-cycle read latency.
  always @(posedge clock) if (imem_rd) imem_dout <= imem_addr ^ 16'hA5A5;

  localparam logic [3:0] C_V = 4'h1, C_RD = 4'h2, C_A = 4'h4, C_D = 4'h8;
  localparam logic [3:0] ALL = 4'hF, NOD = 4'h7, RDO = 4'h2;

  typedef struct {
    bit          rst, en, rdy, br;
    logic [15:0] ta;
    logic [3:0]  chk;
    bit          v, rd;
    logic [15:0] a, i, n;
  } vec_t;

  typedef struct {
    logic [15:0] instr, npc;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int n_pass = 0, n_total = 0;
  logic [15:0] exp_fetch = 16'd0, exp_flush = 16'd0;

  function automatic vec_t mk(bit rst, bit en, bit rdy, bit br, logic [15:0] ta,
                              logic [3:0] chk, bit v, bit rd, logic [15:0] a,
                              logic [15:0] ia);
    vec_t r;
    r.rst = rst; r.en = en; r.rdy = rdy; r.br = br; r.ta = ta;
    r.chk = chk; r.v = v; r.rd = rd; r.a = a;
    r.i = ia ^ 16'hA5A5;
    r.n = ia + 16'd1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  // Reference model updated just before each rising edge.
  task automatic sb_update();
    exp_t e;
    if (reset) begin
      sbq.delete();
      exp_fetch = 16'd0;
      exp_flush = 16'd0;
      return;
    end
    if (dec_valid) begin
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL sb_head: dec_valid with no outstanding fetch, instr %h", dec_instr);
      end else begin
        chk("sb_instr", dec_instr, sbq[0].instr);
        chk("sb_npc", dec_npc, sbq[0].npc);
        if (dec_ready) begin
          void'(sbq.pop_front());
          exp_fetch = exp_fetch + 16'd1;
        end
      end
    end
    if (br_taken) begin
      sbq.delete();
      exp_flush = exp_flush + 16'd1;
    end
    if (imem_rd) begin
      e.instr = imem_addr ^ 16'hA5A5;
      e.npc   = imem_addr + 16'd1;
      sbq.push_back(e);
    end
  endtask

  task automatic run_row(input vec_t v, input int k);
    @(negedge clock);
    reset = v.rst; enable_updatePC = v.en; dec_ready = v.rdy;
    br_taken = v.br; taddr = v.ta;
    #1;
    if (v.chk[0]) chk($sformatf("r%0d dec_valid", k), {15'd0, dec_valid}, {15'd0, v.v});
    if (v.chk[1]) chk($sformatf("r%0d imem_rd", k), {15'd0, imem_rd}, {15'd0, v.rd});
    if (v.chk[2]) chk($sformatf("r%0d imem_addr", k), imem_addr, v.a);
    if (v.chk[3]) begin
      chk($sformatf("r%0d dec_instr", k), dec_instr, v.i);
      chk($sformatf("r%0d dec_npc", k), dec_npc, v.n);
    end
`ifdef LC3_FETCH_PERF_CNT_EN
    chk($sformatf("r%0d fetch_count", k), fetch_count, exp_fetch);
    chk($sformatf("r%0d flush_count", k), flush_count, exp_flush);
`endif
    #2;
    sb_update();
  endtask

  initial begin
    repeat (2) @(negedge clock);
    #1;
    chk("rst dec_valid", {15'd0, dec_valid}, 16'd0);
    chk("rst imem_rd", {15'd0, imem_rd}, 16'd0);
    chk("rst imem_addr", imem_addr, 16'h3000);
    chk("rst dec_instr", dec_instr, 16'h0000);
    chk("rst dec_npc", dec_npc, 16'h0000);

    // Streaming from reset with decode always ready
    vecs.push_back(mk(0,1,1,0,0, NOD,0,1,16'h3000,0));
    vecs.push_back(mk(0,1,1,0,0, NOD,0,1,16'h3001,0));
    vecs.push_back(mk(0,1,1,0,0, ALL,1,1,16'h3002,16'h3000));
    vecs.push_back(mk(0,1,1,0,0, ALL,1,1,16'h3003,16'h3001));
    vecs.push_back(mk(0,1,1,0,0, ALL,1,1,16'h3004,16'h3002));
    vecs.push_back(mk(1,1,1,0,0, RDO,0,0,0,0));
    // Decode stalled: two reads fill the queue, then fetch stops
    vecs.push_back(mk(0,1,0,0,0, NOD,0,1,16'h3000,0));
    vecs.push_back(mk(0,1,0,0,0, NOD,0,1,16'h3001,0));
    for (int j = 0; j < 6; j++) vecs.push_back(mk(0,1,0,0,0, ALL,1,0,16'h3002,16'h3000));
    vecs.push_back(mk(0,1,1,0,0, ALL,1,1,16'h3002,16'h3000));
    vecs.push_back(mk(0,1,1,0,0, ALL,1,1,16'h3003,16'h3001));
    vecs.push_back(mk(0,1,1,0,0, ALL,1,1,16'h3004,16'h3002));
    // Redirect with one entry queued and one read in flight
    vecs.push_back(mk(0,1,0,1,16'h4000, ALL,1,0,16'h3005,16'h3003));
    vecs.push_back(mk(0,1,1,0,0, NOD,0,1,16'h4000,0));
    vecs.push_back(mk(0,1,1,0,0, NOD,0,1,16'h4001,0));
    vecs.push_back(mk(0,1,1,0,0, ALL,1,1,16'h4002,16'h4000));
    // Fetch disabled: in-flight read still lands, queue drains
    vecs.push_back(mk(0,0,1,0,0, ALL,1,0,16'h4003,16'h4001));
    vecs.push_back(mk(0,0,1,0,0, ALL,1,0,16'h4003,16'h4002));
    vecs.push_back(mk(0,0,1,0,0, NOD,0,0,16'h4003,0));
    vecs.push_back(mk(0,1,1,0,0, NOD,0,1,16'h4003,0));
    vecs.push_back(mk(0,1,1,0,0, NOD,0,1,16'h4004,0));
    vecs.push_back(mk(0,1,1,0,0, ALL,1,1,16'h4005,16'h4003));
    // Redirect with a same-cycle pop, then PC wrap at 16'hFFFF
    vecs.push_back(mk(0,1,1,1,16'hFFFE, ALL,1,0,16'h4006,16'h4004));
    vecs.push_back(mk(0,1,1,0,0, NOD,0,1,16'hFFFE,0));
    vecs.push_back(mk(0,1,1,0,0, NOD,0,1,16'hFFFF,0));
    vecs.push_back(mk(0,1,1,0,0, ALL,1,1,16'h0000,16'hFFFE));
    vecs.push_back(mk(0,1,1,0,0, ALL,1,1,16'h0001,16'hFFFF));
    vecs.push_back(mk(0,1,1,0,0, ALL,1,1,16'h0002,16'h0000));
    // One-cycle reset mid-stream
    vecs.push_back(mk(1,1,1,0,0, RDO,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0, NOD,0,1,16'h3000,0));
    vecs.push_back(mk(0,1,1,0,0, NOD,0,1,16'h3001,0));
    vecs.push_back(mk(0,1,1,0,0, ALL,1,1,16'h3002,16'h3000));

    for (int k = 0; k < vecs.size(); k++) run_row(vecs[k], k);

    @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
